// File: rtl/prng_lfsr_gen_if.sv
// prng_lfsr_gen_if: control and observation bundle for the LFSR generator.
//   master : drives LOAD/EN/MODE/SEED, observes PRN/WRAP/PERIOD/SEED_FIX/LOCKUP
//   slave  : the generator side (inputs and outputs reversed)
// WIDTH must match the WIDTH of the generator it is connected to.
interface prng_lfsr_gen_if #(
  parameter int WIDTH = 8
);
  logic             LOAD;
  logic             EN;
  logic             MODE;
  logic [WIDTH-1:0] SEED;
  logic [WIDTH-1:0] PRN;
  logic             WRAP;
  logic [WIDTH-1:0] PERIOD;
  logic             SEED_FIX;
  logic             LOCKUP;

  modport master (
    output LOAD, EN, MODE, SEED,
    input  PRN, WRAP, PERIOD, SEED_FIX, LOCKUP
  );

  modport slave (
    input  LOAD, EN, MODE, SEED,
    output PRN, WRAP, PERIOD, SEED_FIX, LOCKUP
  );
endinterface

// File: rtl/prng_lfsr_gen.sv
// prng_lfsr_gen: WIDTH-bit LFSR pseudo-random generator.
//   Fibonacci or Galois structure, picked at LOAD time. Zero seeds are
//   replaced by 1 (SEED_FIX), a zero state is recovered to 1 (LOCKUP),
//   and the length of each completed cycle back to the seed is reported
//   on PERIOD together with a one-cycle WRAP pulse.
// Ports:
//   SYS_CLK  rising-edge clock
//   SCLR     synchronous active-high clear (wins over LOAD and EN)
//   bus      prng_lfsr_gen_if.slave: LOAD, EN, MODE, SEED in;
//            PRN, WRAP, PERIOD, SEED_FIX, LOCKUP out (all registered)
module prng_lfsr_gen #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
  parameter logic [WIDTH-1:0] RESET_VAL = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic               SYS_CLK,
  input  logic               SCLR,
  prng_lfsr_gen_if.slave     bus
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  // Elaboration-time parameter checks.
  generate
    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
      $error("prng_lfsr_gen: WIDTH must be 4..32");
    end
    if (!TAPS[WIDTH-1]) begin : g_bad_taps
      $error("prng_lfsr_gen: TAPS[WIDTH-1] must be set");
    end
    if (RESET_VAL == ZERO) begin : g_bad_reset_val
      $error("prng_lfsr_gen: RESET_VAL must be nonzero");
    end
  endgenerate

  logic [WIDTH-1:0] prn_q;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] step_cnt_q;
  logic [WIDTH-1:0] period_q;
  logic             mode_q;
  logic             wrap_q;
  logic             seed_fix_q;
  logic             lockup_q;

  logic             fib_fb;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;
  logic [WIDTH-1:0] nxt;

  always_comb begin
    fib_fb   = ^(prn_q & TAPS);
    fib_next = {prn_q[WIDTH-2:0], fib_fb};
    // Galois: the bit shifted out of the MSB is folded back into every
    // tapped position below it, plus the constant term into bit 0.
    gal_next = {prn_q[WIDTH-2:0], 1'b0} ^
               (prn_q[WIDTH-1] ? {TAPS[WIDTH-2:0], 1'b1} : ZERO);
    nxt      = mode_q ? gal_next : fib_next;
  end

  always_ff @(posedge SYS_CLK) begin
    if (SCLR) begin
      prn_q      <= RESET_VAL;
      seed_q     <= RESET_VAL;
      mode_q     <= 1'b0;
      step_cnt_q <= '0;
      period_q   <= '0;
      wrap_q     <= 1'b0;
      seed_fix_q <= 1'b0;
      lockup_q   <= 1'b0;
    end else if (bus.LOAD) begin
      // A zero seed would freeze the register, so substitute 1 and flag it.
      if (bus.SEED == ZERO) begin
        prn_q      <= ONE;
        seed_q     <= ONE;
        seed_fix_q <= 1'b1;
      end else begin
        prn_q      <= bus.SEED;
        seed_q     <= bus.SEED;
        seed_fix_q <= 1'b0;
      end
      mode_q     <= bus.MODE;
      step_cnt_q <= '0;
      wrap_q     <= 1'b0;
    end else if (bus.EN) begin
      if (nxt == ZERO) begin
        // Only reachable from a corrupted zero state; restart the sequence.
        prn_q      <= ONE;
        lockup_q   <= 1'b1;
        step_cnt_q <= '0;
        wrap_q     <= 1'b0;
      end else begin
        prn_q <= nxt;
        if (nxt == seed_q) begin
          wrap_q     <= 1'b1;
          period_q   <= step_cnt_q + ONE;
          step_cnt_q <= '0;
        end else begin
          wrap_q     <= 1'b0;
          step_cnt_q <= step_cnt_q + ONE;
        end
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign bus.PRN      = prn_q;
  assign bus.WRAP     = wrap_q;
  assign bus.PERIOD   = period_q;
  assign bus.SEED_FIX = seed_fix_q;
  assign bus.LOCKUP   = lockup_q;

endmodule
